pc_fetch_stage: RTL and testbench

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

---
 rtl/cpu_pkg.sv | 19 +
 rtl/pc_fetch_stage.sv | 117 +++++++++++
 tb/tb_pc_fetch_stage.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared fetch-state encoding, PC defaults and word width
// Revision: 1.0
// ============================================================================
package cpu_pkg;

  localparam int unsigned c_XLEN     = 32;
  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] c_PC_INC   = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// pc_fetch_stage : PC register plus fetch FSM feeding a one-entry decode slot
// Revision: 1.0
// ============================================================================
module pc_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_RESET_PC,
  parameter logic [31:0] PC_INC   = c_PC_INC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_src,
  input  logic [c_XLEN-1:0]   target_address,
  output logic                imem_req,
  output logic [c_XLEN-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [c_XLEN-1:0]   imem_rdata,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [c_XLEN-1:0]   id_instr,
  output logic [c_XLEN-1:0]   id_pc,
  output logic [c_XLEN-1:0]   id_pc_plus4
);

  fetch_state_e      r_state;
  logic [c_XLEN-1:0] r_pc;
  logic              r_imem_req;
  logic [c_XLEN-1:0] r_imem_addr;
  logic              r_id_valid;
  logic [c_XLEN-1:0] r_id_instr;
  logic [c_XLEN-1:0] r_id_pc;
  logic [c_XLEN-1:0] r_id_pc_plus4;
  logic [c_XLEN-1:0] w_pc_next;

  assign w_pc_next = r_pc + PC_INC;

  // imem_addr is a separate register so DROP can keep the old address while r_pc moves on
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
      r_id_valid    <= 1'b0;
      r_id_instr    <= '0;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
            if (pc_src) begin
              r_pc        <= target_address;
              r_imem_addr <= target_address;
            end else begin
              r_imem_addr <= r_pc;
            end
          end else if (pc_src) begin
            r_pc <= target_address;
            if (imem_ack) begin
              r_imem_addr <= target_address;
            end else begin
              r_state <= DROP;
            end
          end else if (imem_ack) begin
            r_id_valid    <= 1'b1;
            r_id_instr    <= imem_rdata;
            r_id_pc       <= r_pc;
            r_id_pc_plus4 <= w_pc_next;
            r_pc          <= w_pc_next;
            r_imem_req    <= 1'b0;
            r_state       <= STALL;
          end
        end
        STALL: begin
          if (pc_src) begin
            r_id_valid  <= 1'b0;
            r_pc        <= target_address;
            r_imem_addr <= target_address;
            r_imem_req  <= 1'b1;
            r_state     <= FETCH;
          end else if (id_ready) begin
            r_id_valid  <= 1'b0;
            r_imem_addr <= r_pc;
            r_imem_req  <= 1'b1;
            r_state     <= FETCH;
          end
        end
        DROP: begin
          if (pc_src) begin
            r_pc <= target_address;
          end
          if (imem_ack) begin
            r_imem_addr <= pc_src ? target_address : r_pc;
            r_state     <= FETCH;
          end
        end
        default: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch_stage : directed self-checking bench for pc_fetch_stage
// Revision: 1.0
// ============================================================================
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_src;
  logic [31:0] target_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  // memory model answers for whatever address is on the bus
  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  pc_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .pc_src         (pc_src),
    .target_address (target_address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1; pc_src = 1'b0; target_address = '0; imem_ack = 1'b0; id_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; pc_src = 1'b1; target_address = 32'h0000_0500; imem_ack = 1'b1; id_ready = 1'b1;
    tick; tick;
    n_vec++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_ctl: req=%b valid=%b, want 0 0", imem_req, id_valid);
    end
    n_vec++;
    if (id_instr !== 32'h0 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin
      n_err++; $display("FAIL reset_id: instr=%h pc=%h pc4=%h, want 0 0 0", id_instr, id_pc, id_pc_plus4);
    end
    pc_src = 1'b0; imem_ack = 1'b0; id_ready = 1'b0;
    reset = 1'b0;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL reset_release_early: req=%b, want 0", imem_req);
    end
    tick;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_first_req: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait;
    logic [31:0] exp;
    do_reset;
    id_ready = 1'b1;
    exp = 32'h0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== exp) begin
        n_err++; $display("FAIL zw_req k=%0d: req=%b addr=%h, want 1 %h", k, imem_req, imem_addr, exp);
      end
      imem_ack = 1'b1; tick; imem_ack = 1'b0;
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== exp || id_pc_plus4 !== exp + 32'd4 ||
          id_instr !== mem_word(exp) || imem_req !== 1'b0) begin
        n_err++; $display("FAIL zw_out k=%0d: valid=%b pc=%h pc4=%h instr=%h req=%b, want 1 %h %h %h 0",
                          k, id_valid, id_pc, id_pc_plus4, id_instr, imem_req, exp, exp + 32'd4, mem_word(exp));
      end
      tick;
      n_vec++;
      if (id_valid !== 1'b0 || imem_req !== 1'b1) begin
        n_err++; $display("FAIL zw_gap k=%0d: valid=%b req=%b, want 0 1", k, id_valid, imem_req);
      end
      exp = exp + 32'd4;
    end
  endtask

  task automatic test_latency;
    logic [31:0] exp;
    do_reset;
    id_ready = 1'b1;
    exp = 32'h0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== exp) begin
          n_err++; $display("FAIL lat_hold k=%0d c=%0d: req=%b addr=%h, want 1 %h", k, c, imem_req, imem_addr, exp);
        end
        imem_ack = (c == 2);
        tick;
      end
      imem_ack = 1'b0;
      n_vec++;
      if (id_valid !== 1'b1 || id_instr !== mem_word(exp) || id_pc !== exp) begin
        n_err++; $display("FAIL lat_out k=%0d: valid=%b instr=%h pc=%h, want 1 %h %h",
                          k, id_valid, id_instr, id_pc, mem_word(exp), exp);
      end
      tick;
      exp = exp + 32'd4;
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    id_ready = 1'b0;
    imem_ack = 1'b1; tick; imem_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4 ||
          id_instr !== mem_word(32'h0) || imem_req !== 1'b0) begin
        n_err++; $display("FAIL bp_hold c=%0d: valid=%b pc=%h pc4=%h instr=%h req=%b, want 1 0 4 %h 0",
                          c, id_valid, id_pc, id_pc_plus4, id_instr, imem_req, mem_word(32'h0));
      end
      tick;
    end
    id_ready = 1'b1;
    tick;
    n_vec++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      n_err++; $display("FAIL bp_release: valid=%b req=%b addr=%h, want 0 1 00000004", id_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_outstanding;
    do_reset;
    id_ready = 1'b1;
    repeat (2) begin
      imem_ack = 1'b1; tick; imem_ack = 1'b0; tick;
    end
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      n_err++; $display("FAIL rd_pre: req=%b addr=%h, want 1 00000008", imem_req, imem_addr);
    end
    pc_src = 1'b1; target_address = 32'h100;
    tick;
    pc_src = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || id_valid !== 1'b0) begin
        n_err++; $display("FAIL rd_drop c=%0d: req=%b addr=%h valid=%b, want 1 00000008 0", c, imem_req, imem_addr, id_valid);
      end
      if (c == 0) tick;
    end
    imem_ack = 1'b1; tick; imem_ack = 1'b0;
    n_vec++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_err++; $display("FAIL rd_discard: valid=%b req=%b addr=%h, want 0 1 00000100", id_valid, imem_req, imem_addr);
    end
    imem_ack = 1'b1; tick; imem_ack = 1'b0;
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== mem_word(32'h100)) begin
      n_err++; $display("FAIL rd_target: valid=%b pc=%h instr=%h, want 1 00000100 %h", id_valid, id_pc, id_instr, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_ack_and_drop;
    do_reset;
    id_ready = 1'b1;
    pc_src = 1'b1; target_address = 32'h20; imem_ack = 1'b1;
    tick;
    imem_ack = 1'b0; target_address = 32'h40;
    n_vec++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      n_err++; $display("FAIL ra_ack: valid=%b req=%b addr=%h, want 0 1 00000020", id_valid, imem_req, imem_addr);
    end
    tick;
    target_address = 32'h80;
    tick;
    pc_src = 1'b0;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20 || id_valid !== 1'b0) begin
      n_err++; $display("FAIL ra_drop: req=%b addr=%h valid=%b, want 1 00000020 0", imem_req, imem_addr, id_valid);
    end
    imem_ack = 1'b1; tick; imem_ack = 1'b0;
    n_vec++;
    if (id_valid !== 1'b0 || imem_addr !== 32'h80) begin
      n_err++; $display("FAIL ra_refetch: valid=%b addr=%h, want 0 00000080", id_valid, imem_addr);
    end
    imem_ack = 1'b1; tick; imem_ack = 1'b0;
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 32'h80 || id_pc_plus4 !== 32'h84) begin
      n_err++; $display("FAIL ra_target: valid=%b pc=%h pc4=%h, want 1 00000080 00000084", id_valid, id_pc, id_pc_plus4);
    end
  endtask

  task automatic test_reset_mid_and_wrap;
    do_reset;
    id_ready = 1'b1;
    pc_src = 1'b1; target_address = 32'h200;
    tick;
    pc_src = 1'b0;
    reset = 1'b1;
    tick;
    n_vec++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
      n_err++; $display("FAIL rm_abandon: req=%b valid=%b, want 0 0", imem_req, id_valid);
    end
    reset = 1'b0;
    tick;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL rm_restart: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
    pc_src = 1'b1; target_address = 32'hFFFF_FFFC; imem_ack = 1'b1;
    tick;
    pc_src = 1'b0;
    n_vec++;
    if (imem_addr !== 32'hFFFF_FFFC || id_valid !== 1'b0) begin
      n_err++; $display("FAIL wr_addr: addr=%h valid=%b, want fffffffc 0", imem_addr, id_valid);
    end
    tick;
    imem_ack = 1'b0;
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) begin
      n_err++; $display("FAIL wr_out: valid=%b pc=%h pc4=%h, want 1 fffffffc 00000000", id_valid, id_pc, id_pc_plus4);
    end
    tick;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL wr_next: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
  endtask

  initial begin
    reset = 1'b1; pc_src = 1'b0; target_address = '0; imem_ack = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_zero_wait;
    test_latency;
    test_backpressure;
    test_redirect_outstanding;
    test_redirect_ack_and_drop;
    test_reset_mid_and_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
